pipelined_cond_controller: RTL and testbench

- Parametrised successor to the single-cycle CPU controller.
- Decodes the instruction held in IF/ID and carries control through ID/EX, EX/MEM (MEM_STAGES deep) and MEM/WB pipeline registers.
- Evaluates the condition field in EX against an internal NZCV flag register and annuls failed instructions.
- Resolves branches in EX and self-squashes the wrong-path instruction.

---
 rtl/pipelined_cond_controller.sv | 215 +++++++++++++++++++++
 tb/tb_pipelined_cond_controller.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_cond_controller.sv
// rtl/pipelined_cond_controller.sv - pipelined ARM-style controller with EX condition evaluation
// Optional CTRL_ANNUL_CNT_EN adds annul_cnt, a saturating count of condition-failed EX instructions.
module pipelined_cond_controller #(
  parameter int INSTR_W    = 16,
  parameter int ALUC_W     = 3,
  parameter int MEM_STAGES = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INSTR_W-1:0] IF_ID_Instr,
  input  logic [3:0]         ALUFlags,
  input  logic               FlushE,
  output logic [1:0]         RegSrcD,
  output logic [1:0]         ImmSrcD,
  output logic               ALUSrcE,
  output logic [ALUC_W-1:0]  ALUControlE,
  output logic               PCSrcE,
  output logic               BranchTakenE,
  output logic               MemWriteM,
  output logic               MemtoRegM,
  output logic               RegWriteM,
  output logic               RegWriteW,
  output logic               MemtoRegW,
`ifdef CTRL_ANNUL_CNT_EN
  output logic [3:0]         Flags,
  output logic [15:0]        annul_cnt
`else
  output logic [3:0]         Flags
`endif
);

  localparam int W = INSTR_W;

  logic [3:0] cond_d;
  logic [1:0] op_d;
  logic       i_d, s_d, l_d;
  logic [2:0] cmd_d;
  logic       unused_low_bits;

  assign cond_d          = IF_ID_Instr[W-1 -: 4];
  assign op_d            = IF_ID_Instr[W-5 -: 2];
  assign i_d             = IF_ID_Instr[W-7];
  assign cmd_d           = IF_ID_Instr[W-8 -: 3];
  assign l_d             = IF_ID_Instr[W-8];
  assign s_d             = IF_ID_Instr[W-11];
  assign unused_low_bits = ^IF_ID_Instr[W-12:0];

  logic              alusrc_d, rw_d, mw_d, m2r_d, br_d;
  logic [ALUC_W-1:0] aluc_d;
  logic [1:0]        fw_d;  // {write N/Z, write C/V}

  always_comb begin
    RegSrcD  = 2'b00;
    ImmSrcD  = 2'b00;
    alusrc_d = 1'b0;
    aluc_d   = '0;
    rw_d     = 1'b0;
    mw_d     = 1'b0;
    m2r_d    = 1'b0;
    br_d     = 1'b0;
    fw_d     = 2'b00;
    case (op_d)
      2'b00: begin
        alusrc_d = i_d;
        case (cmd_d)
          3'b000, 3'b001: begin
            aluc_d = ALUC_W'(cmd_d);
            rw_d   = 1'b1;
            fw_d   = {s_d, s_d};
          end
          3'b010, 3'b011, 3'b100: begin
            aluc_d = ALUC_W'(cmd_d);
            rw_d   = 1'b1;
            fw_d   = {s_d, 1'b0};
          end
          3'b101: begin
            aluc_d = ALUC_W'(1);
            fw_d   = 2'b11;
          end
          3'b110: begin
            aluc_d = ALUC_W'(5);
            rw_d   = 1'b1;
            fw_d   = {s_d, 1'b0};
          end
          default: ;
        endcase
      end
      2'b01: begin
        ImmSrcD  = 2'b01;
        alusrc_d = 1'b1;
        rw_d     = l_d;
        m2r_d    = l_d;
        mw_d     = ~l_d;
        RegSrcD  = {~l_d, 1'b0};
      end
      2'b10: begin
        ImmSrcD  = 2'b10;
        alusrc_d = 1'b1;
        br_d     = 1'b1;
        RegSrcD  = 2'b01;
      end
      default: ;
    endcase
  end

  logic [3:0]        e_cond;
  logic              e_rw, e_mw, e_m2r, e_br;
  logic [1:0]        e_fw;
  logic              cond_ex;

  always_ff @(posedge clk) begin
    if (reset || FlushE || BranchTakenE) begin
      e_cond      <= 4'b0000;
      ALUSrcE     <= 1'b0;
      ALUControlE <= '0;
      e_rw        <= 1'b0;
      e_mw        <= 1'b0;
      e_m2r       <= 1'b0;
      e_br        <= 1'b0;
      e_fw        <= 2'b00;
    end else begin
      e_cond      <= cond_d;
      ALUSrcE     <= alusrc_d;
      ALUControlE <= aluc_d;
      e_rw        <= rw_d;
      e_mw        <= mw_d;
      e_m2r       <= m2r_d;
      e_br        <= br_d;
      e_fw        <= fw_d;
    end
  end

  logic fn, fz, fc, fv;
  assign {fn, fz, fc, fv} = Flags;

  always_comb begin
    cond_ex = 1'b0;
    case (e_cond)
      4'b0000: cond_ex = fz;
      4'b0001: cond_ex = ~fz;
      4'b0010: cond_ex = fc;
      4'b0011: cond_ex = ~fc;
      4'b0100: cond_ex = fn;
      4'b0101: cond_ex = ~fn;
      4'b0110: cond_ex = fv;
      4'b0111: cond_ex = ~fv;
      4'b1000: cond_ex = fc & ~fz;
      4'b1001: cond_ex = ~fc | fz;
      4'b1010: cond_ex = (fn == fv);
      4'b1011: cond_ex = (fn != fv);
      4'b1100: cond_ex = ~fz & (fn == fv);
      4'b1101: cond_ex = fz | (fn != fv);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  assign PCSrcE       = e_br & cond_ex;
  assign BranchTakenE = PCSrcE;

  // Flags written here are visible to the very next EX instruction.
  always_ff @(posedge clk) begin
    if (reset) begin
      Flags <= 4'b0000;
    end else begin
      if (e_fw[1] && cond_ex) Flags[3:2] <= ALUFlags[3:2];
      if (e_fw[0] && cond_ex) Flags[1:0] <= ALUFlags[1:0];
    end
  end

  logic [MEM_STAGES-1:0] m_rw, m_m2r;
  logic                  m_mw;

  always_ff @(posedge clk) begin
    if (reset) begin
      m_rw      <= '0;
      m_m2r     <= '0;
      m_mw      <= 1'b0;
      RegWriteW <= 1'b0;
      MemtoRegW <= 1'b0;
    end else begin
      m_rw[0]  <= e_rw & cond_ex;
      m_m2r[0] <= e_m2r;
      m_mw     <= e_mw & cond_ex;
      for (int k = 1; k < MEM_STAGES; k++) begin
        m_rw[k]  <= m_rw[k-1];
        m_m2r[k] <= m_m2r[k-1];
      end
      RegWriteW <= m_rw[MEM_STAGES-1];
      MemtoRegW <= m_m2r[MEM_STAGES-1];
    end
  end

  assign MemWriteM = m_mw;
  assign MemtoRegM = m_m2r[0];
  assign RegWriteM = m_rw[0];

`ifdef CTRL_ANNUL_CNT_EN
  // Bubbles carry cond=0000, so a separate valid bit keeps them out of the count.
  logic e_valid;

  always_ff @(posedge clk) begin
    if (reset || FlushE || BranchTakenE) e_valid <= 1'b0;
    else                                 e_valid <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset)
      annul_cnt <= 16'h0000;
    else if (e_valid && !cond_ex && annul_cnt != 16'hFFFF)
      annul_cnt <= annul_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_pipelined_cond_controller.sv
// tb/tb_pipelined_cond_controller.sv - self-checking bench for pipelined_cond_controller
module tb_pipelined_cond_controller;
  localparam int W  = 16;
  localparam int AW = 3;
  localparam int MS = 1;
  localparam logic [W-1:0] NOP = 16'hEC00;

  logic          clk = 1'b0;
  logic          reset;
  logic [W-1:0]  IF_ID_Instr;
  logic [3:0]    ALUFlags;
  logic          FlushE;
  logic [1:0]    RegSrcD, ImmSrcD;
  logic          ALUSrcE;
  logic [AW-1:0] ALUControlE;
  logic          PCSrcE, BranchTakenE, MemWriteM, MemtoRegM, RegWriteM, RegWriteW, MemtoRegW;
  logic [3:0]    Flags;
`ifdef CTRL_ANNUL_CNT_EN
  logic [15:0]   annul_cnt;
`endif

  pipelined_cond_controller #(.INSTR_W(W), .ALUC_W(AW), .MEM_STAGES(MS)) dut (
    .clk(clk), .reset(reset), .IF_ID_Instr(IF_ID_Instr), .ALUFlags(ALUFlags), .FlushE(FlushE),
    .RegSrcD(RegSrcD), .ImmSrcD(ImmSrcD), .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE),
    .PCSrcE(PCSrcE), .BranchTakenE(BranchTakenE), .MemWriteM(MemWriteM), .MemtoRegM(MemtoRegM),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW),
`ifdef CTRL_ANNUL_CNT_EN
    .Flags(Flags), .annul_cnt(annul_cnt)
`else
    .Flags(Flags)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Instruction meaning derived from the ISA description.
  typedef struct packed {
    logic [1:0] regsrc;
    logic [1:0] immsrc;
    logic       alusrc;
    logic [2:0] aluc;
    logic       rw, mw, m2r, br, wnz, wcv;
  } info_t;

  function automatic info_t dec_m(input logic [W-1:0] ins);
    info_t r = '0;
    int op  = int'(ins[W-5 -: 2]);
    int cmd = int'(ins[W-8 -: 3]);
    bit i   = ins[W-7];
    bit s   = ins[W-11];
    bit ld  = ins[W-8];
    if (op == 0) begin
      r.alusrc = i;
      if (cmd == 5) begin
        r.aluc = 3'd1; r.wnz = 1'b1; r.wcv = 1'b1;
      end else if (cmd != 7) begin
        r.rw   = 1'b1;
        r.aluc = (cmd == 6) ? 3'd5 : 3'(cmd);
        r.wnz  = s;
        r.wcv  = s && (cmd < 2);
      end
    end else if (op == 1) begin
      r.immsrc = 2'd1; r.alusrc = 1'b1;
      r.rw = ld; r.m2r = ld; r.mw = !ld;
      r.regsrc = ld ? 2'd0 : 2'd2;
    end else if (op == 2) begin
      r.immsrc = 2'd2; r.alusrc = 1'b1; r.br = 1'b1; r.regsrc = 2'd1;
    end
    return r;
  endfunction

  function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
    bit n = f[3], z = f[2], cy = f[1], v = f[0];
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !cy || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Reference state: flags, the EX occupant, and per-cycle schedules of downstream effects.
  logic [3:0]   m_flags = 4'h0;
  bit           m_ex_valid = 1'b0;
  logic [W-1:0] m_ex_instr = '0;
  logic [15:0]  m_annul = 16'h0;
  int           cyc = 0;
  bit           model_on = 1'b0;
  bit em_rw [4096];
  bit em_mw [4096];
  bit em_m2r[4096];
  bit ew_rw [4096];
  bit ew_m2r[4096];

  task automatic model_check();
    info_t d = dec_m(IF_ID_Instr);
    info_t e = m_ex_valid ? dec_m(m_ex_instr) : '0;
    bit tk = m_ex_valid && e.br && cond_ok(m_ex_instr[W-1 -: 4], m_flags);
    chk("m_regsrc",  RegSrcD,      d.regsrc);
    chk("m_immsrc",  ImmSrcD,      d.immsrc);
    chk("m_alusrc",  ALUSrcE,      e.alusrc);
    chk("m_aluc",    ALUControlE,  e.aluc);
    chk("m_pcsrc",   PCSrcE,       tk);
    chk("m_btaken",  BranchTakenE, tk);
    chk("m_memwm",   MemWriteM,    em_mw[cyc]);
    chk("m_m2rm",    MemtoRegM,    em_m2r[cyc]);
    chk("m_rwm",     RegWriteM,    em_rw[cyc]);
    chk("m_rww",     RegWriteW,    ew_rw[cyc]);
    chk("m_m2rw",    MemtoRegW,    ew_m2r[cyc]);
    chk("m_flags",   Flags,        m_flags);
`ifdef CTRL_ANNUL_CNT_EN
    chk("m_annul",   annul_cnt,    m_annul);
`endif
  endtask

  task automatic model_advance();
    if (reset) begin
      m_flags = 4'h0; m_ex_valid = 1'b0; m_annul = 16'h0;
      em_rw[cyc+1] = 0; em_mw[cyc+1] = 0; em_m2r[cyc+1] = 0;
      for (int k = cyc + 1; k <= cyc + 1 + MS; k++) begin
        ew_rw[k] = 0; ew_m2r[k] = 0;
      end
    end else begin
      info_t e = m_ex_valid ? dec_m(m_ex_instr) : '0;
      bit ok = m_ex_valid && cond_ok(m_ex_instr[W-1 -: 4], m_flags);
      bit tk = ok && e.br;
      em_rw[cyc+1]     = e.rw && ok;
      em_mw[cyc+1]     = e.mw && ok;
      em_m2r[cyc+1]    = e.m2r;
      ew_rw[cyc+1+MS]  = e.rw && ok;
      ew_m2r[cyc+1+MS] = e.m2r;
      if (ok && e.wnz) m_flags[3:2] = ALUFlags[3:2];
      if (ok && e.wcv) m_flags[1:0] = ALUFlags[1:0];
      if (m_ex_valid && !ok && m_annul != 16'hFFFF) m_annul++;
      if (FlushE || tk) m_ex_valid = 1'b0;
      else begin
        m_ex_valid = 1'b1; m_ex_instr = IF_ID_Instr;
      end
    end
    cyc++;
  endtask

  task automatic cycle(input logic [W-1:0] ins, input logic [3:0] af, input logic fl, input logic rs);
    IF_ID_Instr = ins; ALUFlags = af; FlushE = fl; reset = rs;
    #1;
    if (model_on) model_check();
    @(posedge clk);
    model_advance();
    #1;
  endtask

  typedef struct {
    logic [W-1:0] instr;
    logic [3:0]   fin;
    logic [1:0]   regsrc, immsrc;
    logic [2:0]   aluc;
    logic         alusrc;
    logic [3:0]   fout;
  } vec_t;

  vec_t vecs[13];
  logic [15:0] base;

  initial begin
    vecs[0]  = '{16'hE260, 4'b1010, 2'b00, 2'b00, 3'd1, 1'b1, 4'b1010};
    vecs[1]  = '{16'hE200, 4'b1001, 2'b00, 2'b00, 3'd0, 1'b1, 4'b1010};
    vecs[2]  = '{16'hE0A0, 4'b0101, 2'b00, 2'b00, 3'd2, 1'b0, 4'b0110};
    vecs[3]  = '{16'hE140, 4'b0011, 2'b00, 2'b00, 3'd1, 1'b0, 4'b0011};
    vecs[4]  = '{16'hE3A0, 4'b0100, 2'b00, 2'b00, 3'd5, 1'b1, 4'b0111};
    vecs[5]  = '{16'hE0C0, 4'b1111, 2'b00, 2'b00, 3'd3, 1'b0, 4'b0111};
    vecs[6]  = '{16'hE120, 4'b1000, 2'b00, 2'b00, 3'd4, 1'b0, 4'b1011};
    vecs[7]  = '{16'hE220, 4'b0001, 2'b00, 2'b00, 3'd0, 1'b1, 4'b0001};
    vecs[8]  = '{16'hE500, 4'b1111, 2'b00, 2'b01, 3'd0, 1'b1, 4'b0001};
    vecs[9]  = '{16'hE400, 4'b1110, 2'b10, 2'b01, 3'd0, 1'b1, 4'b0001};
    vecs[10] = '{16'hE800, 4'b1100, 2'b01, 2'b10, 3'd0, 1'b1, 4'b0001};
    vecs[11] = '{16'hEC00, 4'b1111, 2'b00, 2'b00, 3'd0, 1'b0, 4'b0001};
    vecs[12] = '{16'hE3E0, 4'b1110, 2'b00, 2'b00, 3'd0, 1'b1, 4'b0001};

    cycle(16'hE260, 4'h0, 1'b0, 1'b1);
    model_on = 1'b1;
    cycle(16'hE260, 4'h0, 1'b0, 1'b1);
    chk("rst_rwm",   RegWriteM,   0);
    chk("rst_rww",   RegWriteW,   0);
    chk("rst_m2rw",  MemtoRegW,   0);
    chk("rst_memwm", MemWriteM,   0);
    chk("rst_pcsrc", PCSrcE,      0);
    chk("rst_aluc",  ALUControlE, 0);
    chk("rst_flags", Flags,       0);
    cycle(16'hE260, 4'h0, 1'b0, 1'b0);
    chk("first_ex_aluc",   ALUControlE, 1);
    chk("first_ex_alusrc", ALUSrcE,     1);
    cycle(16'hE200, 4'b0100, 1'b0, 1'b0);
    chk("subs_flags", Flags, 4'b0100);
    cycle(NOP, 4'b1001, 1'b0, 1'b0);
    chk("add_nos_flags", Flags, 4'b0100);

    for (int i = 0; i < 13; i++) begin
      cycle(vecs[i].instr, 4'h0, 1'b0, 1'b0);
      chk($sformatf("v%0d_regsrc", i), RegSrcD,     vecs[i].regsrc);
      chk($sformatf("v%0d_immsrc", i), ImmSrcD,     vecs[i].immsrc);
      chk($sformatf("v%0d_aluc", i),   ALUControlE, vecs[i].aluc);
      chk($sformatf("v%0d_alusrc", i), ALUSrcE,     vecs[i].alusrc);
      cycle(NOP, vecs[i].fin, 1'b0, 1'b0);
      chk($sformatf("v%0d_flags", i),  Flags,       vecs[i].fout);
    end

    // Taken BEQ squashes the following instruction.
    cycle(16'hE140, 4'h0, 1'b0, 1'b0);
    cycle(16'h0800, 4'b0100, 1'b0, 1'b0);
    chk("beq_pcsrc",  PCSrcE,       1);
    chk("beq_btaken", BranchTakenE, 1);
    cycle(16'hE260, 4'h0, 1'b0, 1'b0);
    chk("beq_bubble_aluc",   ALUControlE, 0);
    chk("beq_bubble_alusrc", ALUSrcE,     0);
    cycle(NOP, 4'h0, 1'b0, 1'b0);
    chk("beq_bubble_rwm", RegWriteM, 0);

    // Annulled BNE: no flush, counter bumps once.
    cycle(16'h1800, 4'h0, 1'b0, 1'b0);
    chk("bne_pcsrc", PCSrcE, 0);
    base = m_annul;
    cycle(16'hE260, 4'h0, 1'b0, 1'b0);
    chk("bne_no_bubble", ALUControlE, 1);
`ifdef CTRL_ANNUL_CNT_EN
    chk("bne_annul_cnt", annul_cnt, 32'(base) + 1);
`endif

    // Load / store latency.
    cycle(16'hE500, 4'h0, 1'b0, 1'b0);
    cycle(NOP, 4'h0, 1'b0, 1'b0);
    chk("ldr_m2rm", MemtoRegM, 1);
    chk("ldr_rwm",  RegWriteM, 1);
    for (int k = 0; k < MS; k++) cycle(NOP, 4'h0, 1'b0, 1'b0);
    chk("ldr_rww",  RegWriteW, 1);
    chk("ldr_m2rw", MemtoRegW, 1);
    cycle(16'hE400, 4'h0, 1'b0, 1'b0);
    chk("str_regsrc", RegSrcD, 2'b10);
    cycle(NOP, 4'h0, 1'b0, 1'b0);
    chk("str_memwm", MemWriteM, 1);
    for (int k = 0; k < MS; k++) cycle(NOP, 4'h0, 1'b0, 1'b0);
    chk("str_rww", RegWriteW, 0);

    // FlushE together with a taken branch gives one bubble.
    cycle(16'hE140, 4'h0, 1'b0, 1'b0);
    cycle(16'h0800, 4'b0100, 1'b0, 1'b0);
    cycle(16'hE260, 4'h0, 1'b1, 1'b0);
    chk("dbl_bubble_aluc", ALUControlE, 0);
    cycle(16'hE260, 4'h0, 1'b0, 1'b0);
    chk("dbl_single_bubble", ALUControlE, 1);

    // Reset with a load in the memory stage.
    cycle(16'hE500, 4'h0, 1'b0, 1'b0);
    cycle(NOP, 4'h0, 1'b0, 1'b0);
    chk("rstld_rwm", RegWriteM, 1);
    cycle(NOP, 4'h0, 1'b0, 1'b1);
    chk("rstld_rww",   RegWriteW, 0);
    chk("rstld_flags", Flags,     0);

    for (int i = 0; i < 1500; i++) begin
      logic [W-1:0] ri;
      logic [3:0]   rf;
      ri = W'($urandom);
      rf = 4'($urandom);
      cycle(ri, rf, ($urandom_range(0, 7) == 0), ($urandom_range(0, 63) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
